// File: rtl/as_acc.sv
// Frame accumulator: sums signed 31-bit samples until in_last or a full frame, then holds the result.
// Optional clamping of the result to the 31-bit signed range is enabled with macro AS_ACC_SAT_EN.
module as_acc #(
  parameter int ACC_W = 36,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [30:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W:0]   out_cnt,
  output logic             out_ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: a sample moves when in_valid && in_ready at a rising edge; the
  // result moves when out_valid && out_ready. Neither valid depends on its ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, sample_ext, sum_nxt;
  logic [CNT_W:0]   cnt, cnt_nxt;
  logic             close, ovf_nxt;

  assign sample_ext = {{(ACC_W-31){in_data[30]}}, in_data};
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    close     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt   = sample_ext;
          cnt_nxt   = {{CNT_W{1'b0}}, 1'b1};
          close     = in_last;
          state_nxt = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt   = acc + sample_ext;
          cnt_nxt   = cnt + 1'b1;
          // A full frame closes itself even without in_last.
          close     = in_last || (cnt_nxt == CNT_MAX);
          state_nxt = close ? HOLD : ACC;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AS_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-30){1'b0}}, {30{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-30){1'b1}}, {30{1'b0}}};

  always_comb begin
    sum_nxt = acc_nxt;
    ovf_nxt = 1'b0;
    if ($signed(acc_nxt) > SAT_MAX) begin
      sum_nxt = SAT_MAX;
      ovf_nxt = 1'b1;
    end else if ($signed(acc_nxt) < SAT_MIN) begin
      sum_nxt = SAT_MIN;
      ovf_nxt = 1'b1;
    end
  end
`else
  assign sum_nxt = acc_nxt;
  assign ovf_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (close) begin
        out_sum <= sum_nxt;
        out_cnt <= cnt_nxt;
        out_ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_as_acc.sv
// Directed plus randomised bench for as_acc; a reference model pushes expected frame results to a queue.
module tb_as_acc;
  localparam int ACC_W = 36;
  localparam int CNT_W = 5;
  localparam int W     = ACC_W + CNT_W + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [30:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W:0]   out_cnt;
  logic             out_ovf;
  logic [1:0]       dbg_state;

  int tests = 0;
  int fails = 0;

  logic [W-1:0]            exp_q[$];
  logic signed [ACC_W-1:0] m_acc = '0;
  int                      m_cnt = 0;

  as_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: push expected result when a frame closes
  task automatic model_sample(input logic [30:0] d, input logic l);
    logic signed [ACC_W-1:0] s, e_sum;
    logic e_ovf;
    s = {{(ACC_W-31){d[30]}}, d};
    if (m_cnt == 0) m_acc = s;
    else m_acc = m_acc + s;
    m_cnt++;
    if (l || m_cnt == (1 << CNT_W)) begin
      e_sum = m_acc;
      e_ovf = 1'b0;
`ifdef AS_ACC_SAT_EN
      if (m_acc > 36'sh03FFFFFFF) begin e_sum = 36'sh03FFFFFFF; e_ovf = 1'b1; end
      else if (m_acc < -36'sh040000000) begin e_sum = -36'sh040000000; e_ovf = 1'b1; end
`endif
      exp_q.push_back({e_sum, 6'(m_cnt), e_ovf});
      m_cnt = 0;
    end
  endtask

  // driver: present one sample and wait (bounded) for its transfer
  task automatic send(input logic [30:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("send_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_sample(d, l);
  endtask

  // monitor: result must appear one cycle after the closing transfer, then hand off to IDLE
  task automatic collect(input string tag);
    int n;
    logic [W-1:0] e;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(0));
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 64'(out_sum), 64'(e[W-1:CNT_W+2]));
      check({tag, "_cnt"}, 64'(out_cnt), 64'(e[CNT_W+1:1]));
      check({tag, "_ovf"}, 64'(out_ovf), 64'(e[0]));
    end
    @(negedge clk);
    check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_idle_state"}, 64'(dbg_state), 64'(0));
  endtask

  initial begin
    logic [30:0] r;
    int len;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_out_cnt", 64'(out_cnt), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_state", 64'(dbg_state), 64'(0));

    // 5, -3, 10 -> 12
    send(31'(5), 1'b0);
    send(31'(-3), 1'b0);
    send(31'(10), 1'b1);
    @(negedge clk);
    check("basic_const_sum", 64'(out_sum), 64'(12));
    check("basic_const_cnt", 64'(out_cnt), 64'(3));
    #1;
    @(posedge clk);
    // re-align: collect starts on the current HOLD cycle's handoff already done
    #1;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    check("basic_idle", 64'(dbg_state), 64'(0));

    // single -7
    send(31'(-7), 1'b1);
    collect("single_neg");

    // 32 ones with no in_last, then sample 33 opens a new frame
    for (int i = 0; i < 32; i++) send(31'(1), 1'b0);
    collect("full_frame");
    send(31'(1), 1'b1);
    collect("after_full");

    // large positive and negative pairs
    send(31'h3FFFFFFF, 1'b0);
    send(31'h3FFFFFFF, 1'b1);
    collect("big_pos");
    send(31'h40000000, 1'b0);
    send(31'h40000000, 1'b1);
    collect("big_neg");

    // back-pressure in HOLD while a sample is offered
    out_ready = 1'b0;
    send(31'(3), 1'b0);
    send(31'(-1), 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 31'(99);
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_sum", 64'(out_sum), 64'(2));
      check("hold_cnt", 64'(out_cnt), 64'(2));
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_exit_state", 64'(dbg_state), 64'(0));
    check("hold_exit_valid", 64'(out_valid), 64'(0));

    // asynchronous reset mid-frame discards the partial frame
    send(31'(6), 1'b0);
    send(31'(7), 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", 64'(out_sum), 64'(0));
    check("async_rst_cnt", 64'(out_cnt), 64'(0));
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_state", 64'(dbg_state), 64'(0));
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(31'(4), 1'b1);
    @(negedge clk);
    check("post_rst_sum", 64'(out_sum), 64'(4));
    check("post_rst_cnt", 64'(out_cnt), 64'(1));
    @(posedge clk);
    #1;
    void'(exp_q.pop_front());

    // random frames
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        r = 31'($urandom);
        send(r, i == len - 1);
      end
      collect("rand_frame");
    end

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/as_acc.md
AS_ACC -- requirements
Module: as_acc

Interface
REQ-001 Parameter ACC_W, default 36, accumulator and output sum width in bits.
REQ-002 Parameter CNT_W, default 5, sample counter width; maximum frame length is 2^CNT_W samples.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  31  signed two's-complement sample (31-bit add/sub stage result).
REQ-008 in_last  input  1  marks final sample of a frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_sum  output  ACC_W  signed frame sum.
REQ-012 out_cnt  output  CNT_W+1  number of samples in the frame.
REQ-013 out_ovf  output  1  result was clamped (see Configuration).

Function
REQ-014 Transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; result handoff SHALL occur when out_valid and out_ready are both 1.
REQ-015 FSM SHALL have three states: IDLE, ACC, HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and ACC, 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-017 IDLE transfer: acc <= sign-extend(in_data) to ACC_W, cnt <= 1; next state HOLD if in_last, else ACC.
REQ-018 ACC transfer: acc <= acc + sign-extend(in_data), cnt <= cnt + 1; next state HOLD if in_last or new cnt equals 2^CNT_W, else ACC.
REQ-019 A frame reaching 2^CNT_W samples without in_last SHALL close on that sample; the following sample starts a new frame.
REQ-020 No transfer SHALL leave acc, cnt, and state unchanged.
REQ-021 out_sum, out_cnt, out_ovf SHALL be registered and stable throughout HOLD; out_valid SHALL rise the cycle after the closing transfer (latency 1).
REQ-022 HOLD handoff SHALL return to IDLE next cycle; in_valid during the handoff cycle is not accepted (in_ready=0).
REQ-023 HOLD with out_ready=0 SHALL persist indefinitely, holding outputs.
REQ-024 Accumulation SHALL be exact: ACC_W >= 31 + CNT_W, guaranteeing no internal wrap.
REQ-025 in_data and in_last SHALL be ignored when in_valid=0.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, acc=0, cnt=0, out_sum=0, out_cnt=0, out_ovf=0, out_valid=0; in_ready SHALL be 1 after reset release.
REQ-027 Reset mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.

Configuration
REQ-028 Macro AS_ACC_SAT_EN defined: out_sum SHALL be clamped to the 31-bit signed range [-2^30, 2^30-1], sign-extended to ACC_W, with out_ovf=1 iff clamping occurred.
REQ-029 Macro AS_ACC_SAT_EN undefined: out_sum SHALL equal the full-precision acc; out_ovf SHALL be constant 0.

Verification
REQ-030 Reset, then samples 5, -3, 10 (last on 10), out_ready=1 -> out_valid one cycle after third transfer, out_sum=12, out_cnt=3, out_ovf=0.
REQ-031 Single sample -7 with in_last in IDLE -> out_sum=-7 (all ones above bit 2), out_cnt=1, return to IDLE after handoff.
REQ-032 32 samples of 1 without in_last -> frame closes on sample 32, out_sum=32, out_cnt=32; sample 33 opens new frame after handoff.
REQ-033 Two samples 2^30-1 each, last on second: SAT_EN -> out_sum=2^30-1, out_ovf=1; without -> out_sum=2^31-2, out_ovf=0.
REQ-034 HOLD with out_ready=0 for 10 cycles while in_valid=1 -> in_ready=0, outputs stable, no sample absorbed; on out_ready=1, IDLE next cycle.
REQ-035 rst_n pulsed low after two samples of a frame -> outputs zero asynchronously, no out_valid; next frame 4 (last) -> out_sum=4, out_cnt=1.
